// File: rtl/id_stage_hz.sv
// Decode stage: control decode, bypassed register file, load-use detection,
// bubble insertion and the ID/EX pipeline register with a saturating stall counter.
module id_stage_hz #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int STALL_CNT_W = 16,
  localparam int RA_W       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   if_id_valid,
  input  logic [DATA_W-1:0]      if_id_npc,
  input  logic [31:0]            if_id_instr,
  input  logic                   wb_we,
  input  logic [RA_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic                   ex_hold,
  input  logic                   ex_flush,
  output logic                   id_stall,
  output logic                   id_ex_valid,
  output logic [8:0]             id_ex_control,
  output logic [DATA_W-1:0]      id_ex_npc,
  output logic [DATA_W-1:0]      id_ex_read_data1,
  output logic [DATA_W-1:0]      id_ex_read_data2,
  output logic [DATA_W-1:0]      id_ex_sign_ext,
  output logic [RA_W-1:0]        id_ex_rs,
  output logic [RA_W-1:0]        id_ex_rt,
  output logic [RA_W-1:0]        id_ex_rd,
  output logic [STALL_CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic              valid;
    logic [8:0]        control;
    logic [DATA_W-1:0] npc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] sext;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
  } idex_t;

  idex_t idex_q, idex_d, dec;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rf_q [NUM_REGS];

  logic [RA_W-1:0]   rs, rt, rd;
  logic [DATA_W-1:0] rd1, rd2;
  logic [8:0]        ctrl;
  logic              lu;

  assign rs = if_id_instr[21 +: RA_W];
  assign rt = if_id_instr[16 +: RA_W];
  assign rd = if_id_instr[11 +: RA_W];

  always_comb begin
    unique case (if_id_instr[31:26])
      6'b000000: ctrl = 9'b1_10_0_0_0_0_0_1;
      6'b100011: ctrl = 9'b0_00_1_0_1_0_1_1;
      6'b101011: ctrl = 9'b0_00_1_0_0_1_0_0;
      6'b000100: ctrl = 9'b0_01_0_1_0_0_0_0;
      default:   ctrl = 9'b0;
    endcase
  end

  // Writeback in the same cycle wins over the stored value.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (rs != '0) begin
      if (wb_we && wb_addr == rs)   rd1 = wb_data;
      else if (int'(rs) < NUM_REGS) rd1 = rf_q[rs];
    end
    if (rt != '0) begin
      if (wb_we && wb_addr == rt)   rd2 = wb_data;
      else if (int'(rt) < NUM_REGS) rd2 = rf_q[rt];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
    end else if (wb_we && wb_addr != '0 && int'(wb_addr) < NUM_REGS) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign lu = if_id_valid && idex_q.valid && idex_q.control[3] && idex_q.rt != '0 &&
              (idex_q.rt == rs || idex_q.rt == rt);
  assign id_stall = ex_hold | (lu & ~ex_flush);

  always_comb begin
    dec         = '0;
    dec.valid   = if_id_valid;
    dec.control = if_id_valid ? ctrl : 9'b0;
    dec.npc     = if_id_npc;
    dec.rd1     = rd1;
    dec.rd2     = rd2;
    dec.sext    = DATA_W'($signed(if_id_instr[15:0]));
    dec.rs      = rs;
    dec.rt      = rt;
    dec.rd      = rd;
  end

  // Hold freezes everything, including a pending flush; a bubble is an all-zero entry.
  always_comb begin
    idex_d = idex_q;
    cnt_d  = cnt_q;
    if (!ex_hold) begin
      if (ex_flush) begin
        idex_d = '0;
      end else if (lu) begin
        idex_d = '0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end else begin
        idex_d = dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idex_q <= '0;
      cnt_q  <= '0;
    end else begin
      idex_q <= idex_d;
      cnt_q  <= cnt_d;
    end
  end

  assign id_ex_valid      = idex_q.valid;
  assign id_ex_control    = idex_q.control;
  assign id_ex_npc        = idex_q.npc;
  assign id_ex_read_data1 = idex_q.rd1;
  assign id_ex_read_data2 = idex_q.rd2;
  assign id_ex_sign_ext   = idex_q.sext;
  assign id_ex_rs         = idex_q.rs;
  assign id_ex_rt         = idex_q.rt;
  assign id_ex_rd         = idex_q.rd;
  assign stall_count      = cnt_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed + randomized bench for id_stage_hz against a cycle-level reference model.
module tb_id_stage_hz;
  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int RA  = 5;
  // Narrow counter so saturation is reachable in a short run.
  localparam int SCW = 10;
  localparam int CMAX = (1 << SCW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset, if_id_valid, wb_we, ex_hold, ex_flush;
  logic [DW-1:0]  if_id_npc, wb_data;
  logic [31:0]    if_id_instr;
  logic [RA-1:0]  wb_addr;
  logic           id_stall, id_ex_valid;
  logic [8:0]     id_ex_control;
  logic [DW-1:0]  id_ex_npc, id_ex_read_data1, id_ex_read_data2, id_ex_sign_ext;
  logic [RA-1:0]  id_ex_rs, id_ex_rt, id_ex_rd;
  logic [SCW-1:0] stall_count;

  id_stage_hz #(.DATA_W(DW), .NUM_REGS(NR), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .reset(reset), .if_id_valid(if_id_valid), .if_id_npc(if_id_npc),
    .if_id_instr(if_id_instr), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_hold(ex_hold), .ex_flush(ex_flush), .id_stall(id_stall), .id_ex_valid(id_ex_valid),
    .id_ex_control(id_ex_control), .id_ex_npc(id_ex_npc), .id_ex_read_data1(id_ex_read_data1),
    .id_ex_read_data2(id_ex_read_data2), .id_ex_sign_ext(id_ex_sign_ext), .id_ex_rs(id_ex_rs),
    .id_ex_rt(id_ex_rt), .id_ex_rd(id_ex_rd), .stall_count(stall_count)
  );

  int checks = 0;
  int fails  = 0;

  // Reference model: architectural registers plus the instruction sitting in EX.
  logic [DW-1:0] m_rf [NR];
  bit            m_v, m_is_load;
  logic [8:0]    m_c;
  logic [DW-1:0] m_npc, m_r1, m_r2, m_sx;
  logic [RA-1:0] m_rs, m_rt, m_rd;
  int            m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ctrl_of(input logic [5:0] op);
    case (op)
      6'h00:   return 9'h181;
      6'h23:   return 9'h02B;
      6'h2B:   return 9'h024;
      6'h04:   return 9'h050;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [DW-1:0] rdval(input logic [4:0] a);
    if (a == 0) return '0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic bit m_lu();
    return if_id_valid && m_v && m_is_load && m_rt != 0 &&
           (m_rt == if_id_instr[25:21] || m_rt == if_id_instr[20:16]);
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] s, t, d);
    return {6'h00, s, t, d, 5'h0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s, t,
                                        input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  task automatic model_edge();
    if (!reset) begin
      for (int i = 0; i < NR; i++) m_rf[i] = '0;
      m_v = 0; m_is_load = 0; m_c = '0; m_cnt = 0;
      m_npc = '0; m_r1 = '0; m_r2 = '0; m_sx = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    end else begin
      if (!ex_hold) begin
        if (ex_flush || m_lu()) begin
          if (!ex_flush) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
          m_v = 0; m_is_load = 0; m_c = '0;
        end else begin
          m_v       = if_id_valid;
          m_c       = if_id_valid ? ctrl_of(if_id_instr[31:26]) : 9'h0;
          m_is_load = if_id_valid && if_id_instr[31:26] == 6'h23;
          m_npc     = if_id_npc;
          m_r1      = rdval(if_id_instr[25:21]);
          m_r2      = rdval(if_id_instr[20:16]);
          m_sx      = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
          m_rs      = if_id_instr[25:21];
          m_rt      = if_id_instr[20:16];
          m_rd      = if_id_instr[15:11];
        end
      end
      if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("id_stall", id_stall, ex_hold | (m_lu() & ~ex_flush));
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", id_ex_valid, m_v);
    chk("control", id_ex_control, m_c);
    chk("stall_count", stall_count, m_cnt);
    if (m_v) begin
      chk("npc", id_ex_npc, m_npc);
      chk("rd1", id_ex_read_data1, m_r1);
      chk("rd2", id_ex_read_data2, m_r2);
      chk("sext", id_ex_sign_ext, m_sx);
      chk("rs", id_ex_rs, m_rs);
      chk("rt", id_ex_rt, m_rt);
      chk("rd", id_ex_rd, m_rd);
    end
  endtask

  initial begin
    bit hold_ifid;
    reset = 0; if_id_valid = 0; if_id_npc = '0; if_id_instr = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0; ex_hold = 0; ex_flush = 0;
    m_v = 0; m_is_load = 0; m_c = '0; m_cnt = 0;
    for (int i = 0; i < NR; i++) m_rf[i] = '0;

    // T1: reset
    step(); step();
    chk("T1_valid", id_ex_valid, 1'b0);
    chk("T1_ctrl", id_ex_control, 9'h0);
    chk("T1_npc", id_ex_npc, 32'h0);
    chk("T1_rd1", id_ex_read_data1, 32'h0);
    chk("T1_rd2", id_ex_read_data2, 32'h0);
    chk("T1_sext", id_ex_sign_ext, 32'h0);
    chk("T1_regs", {id_ex_rs, id_ex_rt, id_ex_rd}, 15'h0);
    chk("T1_cnt", stall_count, 10'h0);
    chk("T1_stall", id_stall, 1'b0);
    reset = 1;

    // T2: write r5, then add r3,r5,r0
    wb_we = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    step();
    wb_we = 0; if_id_valid = 1; if_id_npc = 32'h104; if_id_instr = rtype(5, 0, 3);
    step();
    chk("T2_rd1", id_ex_read_data1, 32'hDEADBEEF);
    chk("T2_ctrl", id_ex_control, 9'h181);
    chk("T2_valid", id_ex_valid, 1'b1);

    // T3: same-cycle bypass, then write to r0 is ignored
    wb_we = 1; wb_addr = 7; wb_data = 32'h1234; if_id_instr = rtype(7, 0, 1);
    step();
    chk("T3_bypass", id_ex_read_data1, 32'h1234);
    wb_addr = 0; wb_data = 32'h55; if_id_instr = rtype(0, 7, 2);
    step();
    chk("T3_r0", id_ex_read_data1, 32'h0);
    chk("T3_r7", id_ex_read_data2, 32'h1234);
    wb_we = 0;
    step();
    chk("T3_r0_after", id_ex_read_data1, 32'h0);

    // T4: load-use stall
    if_id_instr = itype(6'h23, 1, 2, 16'd4);
    step();
    if_id_instr = rtype(2, 2, 4);
    #1 chk("T4_stall", id_stall, 1'b1);
    step();
    chk("T4_bubble_v", id_ex_valid, 1'b0);
    chk("T4_bubble_c", id_ex_control, 9'h0);
    chk("T4_cnt", stall_count, 10'd1);
    #1 chk("T4_release", id_stall, 1'b0);
    step();
    chk("T4_issue_v", id_ex_valid, 1'b1);
    chk("T4_issue_c", id_ex_control, 9'h181);

    // T5: flush beats the hazard, then hold freezes ID/EX
    if_id_instr = itype(6'h23, 1, 2, 16'd4);
    step();
    if_id_instr = rtype(2, 2, 4); ex_flush = 1;
    #1 chk("T5_flush_stall", id_stall, 1'b0);
    step();
    chk("T5_flush_v", id_ex_valid, 1'b0);
    chk("T5_flush_cnt", stall_count, 10'd1);
    ex_flush = 0; if_id_instr = itype(6'h23, 1, 2, 16'd4);
    step();
    ex_hold = 1; ex_flush = 1; if_id_instr = rtype(9, 9, 9);
    for (int k = 0; k < 3; k++) begin
      #1 chk("T5_hold_stall", id_stall, 1'b1);
      step();
      chk("T5_hold_v", id_ex_valid, 1'b1);
      chk("T5_hold_c", id_ex_control, 9'h02B);
      chk("T5_hold_imm", id_ex_sign_ext, 32'd4);
    end
    ex_hold = 0; ex_flush = 0;
    step();

    // T6: sign extension, unknown opcode, counter saturation
    if_id_instr = itype(6'h23, 3, 4, 16'h8000);
    step();
    chk("T6_sext", id_ex_sign_ext, 32'hFFFF8000);
    if_id_instr = {6'h3F, 26'h0};
    step();
    chk("T6_nop_c", id_ex_control, 9'h0);
    chk("T6_nop_v", id_ex_valid, 1'b1);
    if_id_instr = itype(6'h23, 2, 2, 16'h0);
    repeat (2 * (CMAX + 1) + 8) step();
    chk("T6_sat", stall_count, CMAX);

    // Reset in the middle of a load-use stall
    if_id_instr = rtype(0, 0, 0);
    step();
    if_id_instr = itype(6'h23, 1, 2, 16'h0);
    step();
    if_id_instr = rtype(2, 2, 4); reset = 0;
    step();
    chk("RST_v", id_ex_valid, 1'b0);
    chk("RST_cnt", stall_count, 10'd0);
    reset = 1;
    #1 chk("RST_nostall", id_stall, 1'b0);
    step();
    chk("RST_issue_v", id_ex_valid, 1'b1);
    chk("RST_issue_c", id_ex_control, 9'h181);
    chk("RST_issue_rd1", id_ex_read_data1, 32'h0);

    // Randomized traffic; IF/ID is held whenever the stage asked for a stall
    repeat (600) begin
      hold_ifid = ex_hold | (m_lu() & ~ex_flush);
      reset    = ($urandom_range(0, 79) != 0);
      ex_hold  = ($urandom_range(0, 5) == 0);
      ex_flush = ($urandom_range(0, 5) == 0);
      wb_we    = $urandom_range(0, 1);
      wb_addr  = RA'($urandom_range(0, 7));
      wb_data  = $urandom;
      if (!hold_ifid) begin
        logic [5:0] op;
        case ($urandom_range(0, 4))
          0: op = 6'h00;
          1: op = 6'h23;
          2: op = 6'h2B;
          3: op = 6'h04;
          default: op = 6'($urandom);
        endcase
        if_id_valid = ($urandom_range(0, 7) != 0);
        if_id_npc   = $urandom;
        if_id_instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
